// File: rtl/pc_seq_ctrl_if.sv
// Handshake bundle between the next-PC sequencer and its surroundings
// (fetch, hazard unit, EX branch resolve, exception logic, PC register).
interface pc_seq_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              imem_ready;
    logic              stall_id;
    logic              branch_req;
    logic [ADDR_W-1:0] branch_addr;
    logic              exc_req;
    logic [ADDR_W-1:0] exc_pc;
    logic              eret_req;
    logic              imem_req;
    logic              pc_enable;
    logic              branch_true;
    logic [ADDR_W-1:0] new_addr;
    logic              flush_if;
    logic              flush_id;
    logic [ADDR_W-1:0] epc;
    logic [1:0]        state_o;

    modport master (
        output imem_ready, stall_id, branch_req, branch_addr, exc_req, exc_pc, eret_req,
        input  imem_req, pc_enable, branch_true, new_addr, flush_if, flush_id, epc, state_o
    );

    modport slave (
        input  imem_ready, stall_id, branch_req, branch_addr, exc_req, exc_pc, eret_req,
        output imem_req, pc_enable, branch_true, new_addr, flush_if, flush_id, epc, state_o
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: arbitrates fetch, stalls, branch/exception/eret redirects,
// holds a redirect pending while imem backpressures, and owns the EPC register.
module pc_seq_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                RESET_HOLD = 2,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0010
) (
    input logic         clk,
    input logic         rst,
    pc_seq_ctrl_if.slave bus
);
    localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic [1:0] {PRI_NONE = 2'd0, PRI_BRANCH = 2'd1, PRI_ERET = 2'd2, PRI_EXC = 2'd3} pri_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  hold_cnt;
    logic              hold_done;
    logic              pend_valid;
    pri_t              pend_pri;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] epc_q;

    pri_t              evt_pri;
    logic [ADDR_W-1:0] evt_addr;
    logic              evt_valid;
    logic              evt_take;
    logic              load_pend;
    logic              clr_pend;
    logic              load_epc;

    // Highest-priority redirect this cycle; eret uses the EPC value before this edge.
    always_comb begin
        evt_pri  = PRI_NONE;
        evt_addr = '0;
        if (bus.exc_req) begin
            evt_pri  = PRI_EXC;
            evt_addr = EXC_VECTOR;
        end else if (bus.eret_req) begin
            evt_pri  = PRI_ERET;
            evt_addr = epc_q;
        end else if (bus.branch_req) begin
            evt_pri  = PRI_BRANCH;
            evt_addr = bus.branch_addr;
        end
    end

    assign evt_valid = (evt_pri != PRI_NONE);
    assign evt_take  = evt_valid && (!pend_valid || (evt_pri >= pend_pri));
    assign hold_done = (hold_cnt == CNT_W'(RESET_HOLD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = BOOT;
        case (state)
            BOOT:    state_nxt = hold_done ? RUN : BOOT;
            RUN:     state_nxt = (evt_valid && !bus.imem_ready) ? WAIT : RUN;
            WAIT:    state_nxt = bus.imem_ready ? RUN : WAIT;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        bus.imem_req    = 1'b0;
        bus.pc_enable   = 1'b0;
        bus.branch_true = 1'b0;
        bus.new_addr    = '0;
        bus.flush_if    = 1'b0;
        bus.flush_id    = 1'b0;
        load_pend       = 1'b0;
        clr_pend        = 1'b0;
        load_epc        = 1'b0;
        case (state)
            RUN: begin
                bus.imem_req = 1'b1;
                if (evt_valid) begin
                    bus.flush_if = 1'b1;
                    bus.flush_id = 1'b1;
                    load_epc     = bus.exc_req;
                    if (bus.imem_ready) begin
                        bus.pc_enable   = 1'b1;
                        bus.branch_true = 1'b1;
                        bus.new_addr    = evt_addr;
                    end else begin
                        load_pend = 1'b1;
                    end
                end else begin
                    bus.pc_enable = bus.imem_ready & ~bus.stall_id;
                end
            end
            WAIT: begin
                bus.imem_req = 1'b1;
                if (evt_take) begin
                    bus.flush_if = 1'b1;
                    bus.flush_id = 1'b1;
                    load_epc     = bus.exc_req;
                end
                if (bus.imem_ready) begin
                    bus.pc_enable   = 1'b1;
                    bus.branch_true = 1'b1;
                    bus.new_addr    = evt_take ? evt_addr : pend_addr;
                    clr_pend        = 1'b1;
                end else begin
                    load_pend = evt_take;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_pri   <= PRI_NONE;
            pend_addr  <= '0;
            epc_q      <= '0;
        end else begin
            hold_cnt <= (state == BOOT && !hold_done) ? hold_cnt + 1'b1 : '0;
            if (load_pend) begin
                pend_valid <= 1'b1;
                pend_pri   <= evt_pri;
                pend_addr  <= evt_addr;
            end else if (clr_pend) begin
                pend_valid <= 1'b0;
                pend_pri   <= PRI_NONE;
            end
            if (load_epc) epc_q <= bus.exc_pc;
        end
    end

    assign bus.epc     = epc_q;
    assign bus.state_o = state;
endmodule
